truth_table_sweeper: RTL and testbench

Sequential characterisation controller for the combinational truth-table logic blocks produced by synthesis, such as the 4-input single-output functions. It drives every input combination into one attached function under test (FUT), waits a fixed settle time, samples the FUT output, and assembles the measured truth table. It then compares the measured table against an expected value latched at start and reports match status and the first failing vector. It sits beside the FUT in self-check and bring-up wrappers.

---
 rtl/truth_table_sweeper_pkg.sv | 19 +
 rtl/truth_table_sweeper_settle_counter.sv | 27 ++
 rtl/truth_table_sweeper.sv | 144 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
// The FSM state enum and the table width derived from the input count live here.
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic int table_w(input int n_inputs);
    return 1 << n_inputs;
  endfunction

  localparam int N_INPUTS_DEFAULT = 4;
  localparam int TABLE_W_DEFAULT  = table_w(N_INPUTS_DEFAULT);

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Loadable down-counter with a zero flag; holds each vector for the settle time.
module settle_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector through an attached function under test, captures its
// truth table (MSB = vector 0) and compares it against a reference latched at start.
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep held
// APPLY  | vector driven, settle counter running
// SAMPLE | FUT output captured on the exiting edge
// DONE   | one-cycle completion, results valid
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int N_INPUTS      = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [table_w(N_INPUTS)-1:0] expected,
  output logic [N_INPUTS-1:0]         dut_in,
  input  logic                        dut_out,
  output logic                        busy,
  output logic                        done,
  output logic                        table_valid,
  output logic [table_w(N_INPUTS)-1:0] measured_table,
  output logic                        match,
  output logic [N_INPUTS-1:0]         first_mismatch
);

  localparam int TABLE_W = table_w(N_INPUTS);
  localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] LAST_VEC    = N_INPUTS'(TABLE_W - 1);

  state_e               state_q;
  logic [N_INPUTS-1:0]  vec_q;
  logic [TABLE_W-1:0]   exp_q;
  logic [TABLE_W-1:0]   meas_q;
  logic                 mism_q;
  logic [N_INPUTS-1:0]  first_q;
  logic                 valid_q;
  logic                 match_q;
  logic                 done_q;

  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic [N_INPUTS-1:0]  bit_idx;
  logic                 bit_diff;

  // TABLE_W-1-vec, kept at N_INPUTS bits since TABLE_W is a power of two.
  assign bit_idx  = LAST_VEC - vec_q;
  assign bit_diff = (dut_out != exp_q[bit_idx]);

  assign cnt_load = ((state_q == IDLE) && start && !abort) ||
                    ((state_q == SAMPLE) && !abort && (vec_q != LAST_VEC));
  assign cnt_dec  = (state_q == APPLY) && !abort;

  settle_counter #(
    .WIDTH (CNT_W)
  ) u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (SETTLE_LOAD),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      exp_q   <= '0;
      meas_q  <= '0;
      mism_q  <= 1'b0;
      first_q <= '0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            exp_q   <= expected;
            meas_q  <= '0;
            mism_q  <= 1'b0;
            first_q <= '0;
            valid_q <= 1'b0;
            match_q <= 1'b0;
            vec_q   <= '0;
            state_q <= APPLY;
          end
        end
        APPLY: begin
          if (abort) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_zero) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            meas_q[bit_idx] <= dut_out;
            if (bit_diff && !mism_q) begin
              first_q <= vec_q;
              mism_q  <= 1'b1;
            end
            if (vec_q == LAST_VEC) begin
              // Fold in the final vector's result so match is correct on entry to DONE.
              match_q <= !(mism_q || bit_diff);
              valid_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              vec_q   <= vec_q + 1'b1;
              state_q <= APPLY;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy           = (state_q == APPLY) || (state_q == SAMPLE);
  assign dut_in         = busy ? vec_q : '0;
  assign done           = done_q;
  assign table_valid    = valid_q;
  assign measured_table = meas_q;
  assign match          = match_q;
  assign first_mismatch = first_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: a behavioural FUT, a scoreboard of expected sweep results,
// timing checks on done, and a second small instance for the 2-input case.
module tb_truth_table_sweeper;

  localparam int NI = 4;
  localparam int SC = 2;
  localparam int TW = 16;
  localparam int LAT = TW * (SC + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, abort;
  logic [TW-1:0] expected, fut;
  logic [NI-1:0] dut_in;
  logic          dut_out;
  logic          busy, done, table_valid, match;
  logic [TW-1:0] measured_table;
  logic [NI-1:0] first_mismatch;

  // Output for vector k lives at fut[TW-1-k], which is ~k for a full-width index.
  assign dut_out = fut[~dut_in];

  truth_table_sweeper #(.N_INPUTS(NI), .SETTLE_CYCLES(SC)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .expected       (expected),
    .dut_in         (dut_in),
    .dut_out        (dut_out),
    .busy           (busy),
    .done           (done),
    .table_valid    (table_valid),
    .measured_table (measured_table),
    .match          (match),
    .first_mismatch (first_mismatch)
  );

  logic       start2, abort2;
  logic [3:0] expected2, fut2, meas2;
  logic [1:0] dut_in2, fm2;
  logic       dut_out2, busy2, done2, valid2, match2;

  assign dut_out2 = fut2[~dut_in2];

  truth_table_sweeper #(.N_INPUTS(2), .SETTLE_CYCLES(1)) u_dut2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start2),
    .abort          (abort2),
    .expected       (expected2),
    .dut_in         (dut_in2),
    .dut_out        (dut_out2),
    .busy           (busy2),
    .done           (done2),
    .table_valid    (valid2),
    .measured_table (meas2),
    .match          (match2),
    .first_mismatch (fm2)
  );

  typedef struct {
    logic [TW-1:0] tbl;
    logic          m;
    logic [NI-1:0] fm;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [TW-1:0] f, input logic [TW-1:0] e);
    exp_t r;
    r.tbl = '0;
    r.m   = 1'b1;
    r.fm  = '0;
    for (int k = 0; k < TW; k++) begin
      r.tbl[TW-1-k] = f[TW-1-k];
      if (r.m && (f[TW-1-k] != e[TW-1-k])) begin
        r.m  = 1'b0;
        r.fm = NI'(k);
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start accepted at the edge inside this task; returns 1 time unit after it.
  task automatic launch(input logic [TW-1:0] f, input logic [TW-1:0] e);
    fut      = f;
    expected = e;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    expected = TW'($urandom);
    sb.push_back(model(f, e));
  endtask

  task automatic wait_done(input int budget, output int edges);
    edges = 0;
    while (!done && edges < budget) begin
      tick();
      edges++;
    end
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_table"}, measured_table, e.tbl);
      check({tag, "_match"}, match, e.m);
      check({tag, "_first"}, first_mismatch, e.fm);
      check({tag, "_valid"}, table_valid, 1'b1);
      check({tag, "_busy"}, busy, 1'b0);
    end
  endtask

  task automatic sweep(input string tag, input logic [TW-1:0] f, input logic [TW-1:0] e);
    int edges;
    launch(f, e);
    check({tag, "_busy_start"}, busy, 1'b1);
    wait_done(LAT + 20, edges);
    check({tag, "_latency"}, edges, LAT);
    compare_result(tag);
    tick();
  endtask

  initial begin
    int edges, edges2, n_done, first_done;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    expected = '0; fut = '0;
    start2 = 1'b0; abort2 = 1'b0; expected2 = '0; fut2 = '0;
    repeat (2) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", table_valid, 1'b0);
    check("rst_table", measured_table, 16'h0);
    check("rst_match", match, 1'b0);
    check("rst_first", first_mismatch, 4'h0);
    check("rst_dut_in", dut_in, 4'h0);
    rst_n = 1'b1;
    tick();

    // start with abort in IDLE is dropped
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy, 1'b0);
    tick();

    sweep("f195_ok",  16'h00C3, 16'h00C3);
    sweep("f195_c2",  16'h00C3, 16'h00C2);
    sweep("f195_80",  16'h00C3, 16'h80C3);
    sweep("rand",     TW'($urandom), TW'($urandom));

    // abort during cycle 10
    launch(16'h00C3, 16'h00C3);
    void'(sb.pop_back());
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_valid", table_valid, 1'b0);
    check("abort_dut_in", dut_in, 4'h0);
    n_done = 0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_valid_hold", table_valid, 1'b0);
    sweep("after_abort", 16'h00C3, 16'h00C3);

    // start pulses while busy are ignored
    launch(16'h00C3, 16'h00C3);
    n_done = 0; first_done = -1;
    for (int n = 1; n <= 60; n++) begin
      start = (n == 5 || n == 20);
      tick();
      start = 1'b0;
      if (done) begin
        n_done++;
        if (first_done < 0) begin
          first_done = n;
          compare_result("pulsed");
        end
      end
    end
    check("pulsed_done_count", n_done, 1);
    check("pulsed_done_edge", first_done, LAT);
    check("pulsed_idle", busy, 1'b0);

    // start held through DONE is taken on the edge after DONE ends
    launch(16'h00C3, 16'h00C3);
    wait_done(LAT + 20, edges);
    check("held_first_latency", edges, LAT);
    compare_result("held_first");
    start = 1'b1;
    expected = 16'h00C2;
    tick();
    check("held_in_idle", busy, 1'b0);
    tick();
    start = 1'b0;
    sb.push_back(model(16'h00C3, 16'h00C2));
    expected = 16'hFFFF;
    check("held_accepted", busy, 1'b1);
    wait_done(LAT + 20, edges2);
    check("held_second_edge", edges + 2 + edges2, 2 * LAT + 2);
    compare_result("held_second");
    tick();

    // asynchronous reset mid-sweep
    launch(16'h00C3, 16'h00C3);
    void'(sb.pop_back());
    repeat (30) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_table", measured_table, 16'h0);
    check("mid_rst_dut_in", dut_in, 4'h0);
    check("mid_rst_valid", table_valid, 1'b0);
    check("mid_rst_match", match, 1'b0);
    check("mid_rst_first", first_mismatch, 4'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    n_done = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (done) n_done++;
    end
    check("mid_rst_no_done", n_done, 0);
    sweep("after_rst", 16'h00C3, 16'h00C3);

    // 2-input instance, XOR FUT
    fut2 = 4'b0110; expected2 = 4'b0110; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    expected2 = 4'b0000;
    edges = 0;
    while (!done2 && edges < 30) begin
      tick();
      edges++;
    end
    check("xor_latency", edges, 8);
    check("xor_table", meas2, 4'b0110);
    check("xor_match", match2, 1'b1);
    check("xor_first", fm2, 2'd0);
    check("xor_valid", valid2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
